// File: rtl/csa_accumulator.sv
// csa_accumulator
// Folds a stream of carry-save (sum, carry) pairs from an 18-bit CSA into
// signed group sums. Each pair is resolved to an 18-bit signed value in
// stage 1, sign-extended in stage 2, and then folded into the accumulator
// by a two-state group FSM (EMPTY / RUN). A pair flagged in_last closes the
// group and presents the sum on out_data.
//
// Optional feature: define CSA_ACC_SAT_EN to make every accumulator
// addition saturate to the signed ACC_W range instead of wrapping.
//
// Handshake: a transfer happens on any rising edge where valid and ready
// are both high. The whole pipeline advances together and freezes only
// when a result is waiting and the consumer is not taking it, so
// in_ready = !(out_valid && !out_ready). out_data never changes while
// out_valid is high and out_ready is low.
module csa_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_s,
    input  logic [17:0]      in_c,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             fsm_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } grp_state_t;

`ifdef CSA_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Pipeline-wide stall: a presented result is not being consumed.
    logic             stall;

    // Stage 1: resolved 18-bit carry-save value.
    logic [17:0]      v_comb;
    logic             s1_valid;
    logic [17:0]      s1_v;
    logic             s1_last;

    // Stage 2: sign-extended value ready to be folded.
    logic             s2_valid;
    logic [ACC_W-1:0] s2_v;
    logic             s2_last;

    // Accumulator and group FSM.
    grp_state_t       state_q;
    grp_state_t       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] sum_add;
    logic [ACC_W-1:0] sum_next;
    logic             fold;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign fsm_state = state_q;

    // The carry vector carries weight 2^(i+1); the 18-bit shift drops bit 17
    // so the result is the CSA value modulo 2^18.
    assign v_comb = in_s + (in_c << 1);

    // Stage 1 register: capture the resolved pair whenever the pipe moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_v     <= v_comb;
            s1_last  <= in_last;
        end
    end

    // Stage 2 register: sign-extend the 18-bit value to accumulator width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_v     <= '0;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_v     <= {{(ACC_W-18){s1_v[17]}}, s1_v};
            s2_last  <= s1_last;
        end
    end

    // Accumulator adder, optionally clamping on signed overflow.
    always_comb begin
        sum_raw = acc_q + s2_v;
`ifdef CSA_ACC_SAT_EN
        if (!acc_q[ACC_W-1] && !s2_v[ACC_W-1] && sum_raw[ACC_W-1]) begin
            sum_add = SAT_MAX;
        end else if (acc_q[ACC_W-1] && s2_v[ACC_W-1] && !sum_raw[ACC_W-1]) begin
            sum_add = SAT_MIN;
        end else begin
            sum_add = sum_raw;
        end
`else
        sum_add = sum_raw;
`endif
    end

    // Group FSM next state: EMPTY starts a fresh sum, RUN keeps adding,
    // a last element always closes the group.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fold     = s2_valid & ~stall;
        sum_next = (state_q == EMPTY) ? s2_v : sum_add;
        if (fold) begin
            acc_d = sum_next;
            if (s2_last) begin
                state_d = EMPTY;
            end else begin
                state_d = RUN;
            end
        end
    end

    // Group FSM and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Result register: load on a closing element, drop once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fold && s2_last) begin
            out_valid <= 1'b1;
            out_data  <= sum_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Busy while any accepted pair is in flight or a group is still open.
    always_comb begin
        busy = s1_valid | s2_valid | (state_q == RUN);
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench for csa_accumulator: directed scenarios plus randomized
// groups, checked against an integer model of the group sums.
module tb_csa_accumulator;

    localparam int ACC_W = 19;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_s;
    logic [17:0]      in_c;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             fsm_state;

    csa_accumulator #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c      (in_c),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] last_out = '0;
    int  acc_cnt    = 0;
    int  ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit  drv_done   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_acc   = 0;
    bit     m_first = 1'b1;

    function automatic longint wrap_signed(input longint x);
        longint m = longint'(1) << ACC_W;
        longint r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_accept(input logic [17:0] s, input logic [17:0] c, input logic last);
        longint v = (longint'(s) + 2 * longint'(c)) % 262144;
        longint lim = longint'(1) << (ACC_W - 1);
        if (v >= 131072) v -= 262144;
        if (m_first) begin
            m_acc = v;
        end else begin
`ifdef CSA_ACC_SAT_EN
            m_acc = m_acc + v;
            if (m_acc > lim - 1) m_acc = lim - 1;
            if (m_acc < -lim) m_acc = -lim;
`else
            m_acc = wrap_signed(m_acc + v);
`endif
        end
        m_first = 1'b0;
        if (last) begin
            exp_q.push_back(m_acc[ACC_W-1:0]);
            m_first = 1'b1;
        end
        acc_cnt++;
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_first = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_pair(input logic [17:0] s, input logic [17:0] c, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_s     = s;
        in_c     = c;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(s, c, last);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 1;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    bit               prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) check("hold_data", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_data), 64'h0bad);
                end else begin
                    check("result", 64'(out_data), 64'(exp_q.pop_front()));
                    last_out = out_data;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int a0;
        int n;
        logic [ACC_W-1:0] e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_s     = '0;
        in_c     = '0;
        in_last  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single pair: 5 + 2*3 = 11, valid two edges after acceptance.
        send_pair(18'h00005, 18'h00003, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("lat_edge_n1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge_n2", 64'(out_valid), 64'd1);
        check("single_value", 64'(out_data), 64'd11);
        drain();

        // Three times -1.
        for (int i = 0; i < 3; i++) send_pair(18'h3FFFF, 18'h0, (i == 2));
        drain();
        e = -3;
        check("minus_three", 64'(last_out), 64'(e));

        // Back-to-back single-pair groups, one per cycle.
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_pair(18'(i * 7 + 1), 18'(i), 1'b1);
        check("b2b_cycles", 64'(cyc - c0), 64'd8);
        drain();

        // Consumer stall with groups queued behind it.
        ready_mode = 2;
        @(posedge clk);
        #2;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_pair(18'(i + 100), 18'd1, 1'b1);
                drv_done = 1'b1;
            end
        join_none
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", 64'(out_valid), 64'd1);
        a0 = acc_cnt;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        check("stall_no_accept", 64'(acc_cnt), 64'(a0));
        ready_mode = 1;
        n = 0;
        while (!drv_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("stall_drv_done", 64'(drv_done), 64'd1);
        drain();

        // Overflow: 0x1FFFF four times.
        for (int i = 0; i < 4; i++) send_pair(18'h1FFFF, 18'h0, (i == 3));
        drain();
`ifdef CSA_ACC_SAT_EN
        e = 19'h3FFFF;
`else
        e = -4;
`endif
        check("overflow_value", 64'(last_out), 64'(e));

        // Reset in the middle of a group discards the partial sum.
        send_pair(18'd1, 18'd0, 1'b0);
        send_pair(18'd2, 18'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_pair(18'd7, 18'd0, 1'b1);
        drain();
        check("after_rst_value", 64'(last_out), 64'd7);

        // Randomized groups with a random consumer.
        ready_mode = 0;
        for (int i = 0; i < 200; i++) begin
            logic [17:0] s;
            logic [17:0] c;
            case ($urandom_range(0, 3))
                0:       s = 18'h1FFFF;
                1:       s = 18'h20000;
                default: s = 18'($urandom_range(0, 18'h3FFFF));
            endcase
            c = 18'($urandom_range(0, 18'h3FFFF));
            send_pair(s, c, ($urandom_range(0, 3) == 0) || (i == 199));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
